// File: rtl/any1_tlb_refill_if.sv
// any1_tlb_refill_if: bundles every non-clock/reset signal of the TLB refill
// engine. Signal suffixes (_i/_o) are given from the refill engine's point of view.
// The refill engine connects through the slave modport. The environment
// (requester, memory, TLB RAM, software) connects through the master modport.
interface any1_tlb_refill_if #(
    parameter int AWID = 32
);
    // Miss request from the TLB lookup
    logic            miss_i;
    logic [AWID-1:0] miss_adr_i;
    logic [7:0]      asid_i;
    logic [AWID-1:0] ptbr_i;

    // Page-table read port
    logic            mreq_o;
    logic [AWID-1:0] madr_o;
    logic            mack_i;
    logic            merr_i;
    logic [63:0]     mdat_i;

    // TLB table port, address is {way[1:0], index[9:0]}
    logic            tlben_o;
    logic            wrtlb_o;
    logic [11:0]     tlbadr_o;
    logic [63:0]     tlbdat_o;
    logic [63:0]     tlbdat_i;

    // Software TLB access
    logic            sw_req_i;
    logic            sw_we_i;
    logic [11:0]     sw_adr_i;
    logic [63:0]     sw_dat_i;
    logic            sw_ack_o;
    logic [63:0]     sw_dat_o;

    // Completion pulses
    logic            done_o;
    logic            fault_o;

    modport slave (
        input  miss_i, miss_adr_i, asid_i, ptbr_i,
        output mreq_o, madr_o,
        input  mack_i, merr_i, mdat_i,
        output tlben_o, wrtlb_o, tlbadr_o, tlbdat_o,
        input  tlbdat_i,
        input  sw_req_i, sw_we_i, sw_adr_i, sw_dat_i,
        output sw_ack_o, sw_dat_o,
        output done_o, fault_o
    );

    modport master (
        output miss_i, miss_adr_i, asid_i, ptbr_i,
        input  mreq_o, madr_o,
        output mack_i, merr_i, mdat_i,
        input  tlben_o, wrtlb_o, tlbadr_o, tlbdat_o,
        output tlbdat_i,
        output sw_req_i, sw_we_i, sw_adr_i, sw_dat_i,
        input  sw_ack_o, sw_dat_o,
        input  done_o, fault_o
    );
endinterface

// File: rtl/any1_tlb_refill.sv
// any1_tlb_refill: hardware page-table walker that refills one TLB entry per
// miss. It also arbitrates software read/write access to the TLB table.
// Optional feature: define ANY1_TLB_REFILL_TIMEOUT_EN to fault a page-table
// read that is not acknowledged within TMO cycles. Without the macro, FETCH
// waits indefinitely.
// All outputs are registered. A software read returns sw_ack_o during SWRD2.
// sw_dat_o is loaded from tlbdat_i at the end of SWRD2, so it is valid from
// the cycle after the acknowledge.
module any1_tlb_refill #(
    parameter int AWID = 32,
    parameter int TMO  = 255
) (
    input  logic                clk_i,
    input  logic                rst_i,
    any1_tlb_refill_if.slave    bus
);
    typedef enum logic [2:0] {
        IDLE, FETCH, WRITE, DONE, FAULT, SWWR, SWRD1, SWRD2
    } state_t;

    state_t           state_reg;
    logic [1:0]       way_reg;
    logic [AWID-1:14] adr_reg;
    logic [7:0]       asid_reg;

    logic             mreq_reg;
    logic [AWID-1:0]  madr_reg;
    logic             tlben_reg;
    logic             wrtlb_reg;
    logic [11:0]      tlbadr_reg;
    logic [63:0]      tlbdat_reg;
    logic             sw_ack_reg;
    logic [63:0]      sw_dat_reg;
    logic             done_reg;
    logic             fault_reg;

`ifdef ANY1_TLB_REFILL_TIMEOUT_EN
    localparam logic [7:0] TMO_LIM = 8'(TMO);
    logic [7:0]       tmo_cnt_reg;
`endif

    // Page-table entry offset: one 8-byte PTE per 16 KiB page.
    logic [AWID-1:0]  walk_off;
    logic [AWID-1:0]  madr_next;
    assign walk_off  = {11'b0, bus.miss_adr_i[AWID-1:14], 3'b000};
    assign madr_next = bus.ptbr_i + walk_off;

    // Build the TLB entry from the arriving PTE and the latched miss context.
    logic [63:0] pte_entry;
    always_comb begin
        pte_entry              = '0;
        pte_entry[63:56]       = asid_reg;
        pte_entry[55]          = bus.mdat_i[5];
        pte_entry[51:48]       = bus.mdat_i[4:1];
        pte_entry[AWID+7:32]   = adr_reg[AWID-1:24];
        pte_entry[AWID-15:0]   = bus.mdat_i[AWID-1:14];
    end

    // PTE bits and page-offset bits that play no part in the refill.
    logic unused_ok;
    assign unused_ok = ^{bus.mdat_i[63:AWID], bus.mdat_i[13:6],
                         bus.miss_adr_i[13:0], 8'(TMO)};

    // Refill / software-access state machine with registered outputs.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_reg   <= IDLE;
            way_reg     <= 2'd0;
            adr_reg     <= '0;
            asid_reg    <= 8'd0;
            mreq_reg    <= 1'b0;
            madr_reg    <= '0;
            tlben_reg   <= 1'b0;
            wrtlb_reg   <= 1'b0;
            tlbadr_reg  <= 12'd0;
            tlbdat_reg  <= 64'd0;
            sw_ack_reg  <= 1'b0;
            sw_dat_reg  <= 64'd0;
            done_reg    <= 1'b0;
            fault_reg   <= 1'b0;
`ifdef ANY1_TLB_REFILL_TIMEOUT_EN
            tmo_cnt_reg <= 8'd0;
`endif
        end else begin
            // Strobes are single-state pulses unless the next state re-asserts them.
            tlben_reg  <= 1'b0;
            wrtlb_reg  <= 1'b0;
            sw_ack_reg <= 1'b0;
            done_reg   <= 1'b0;
            fault_reg  <= 1'b0;

            case (state_reg)
                IDLE: begin
                    if (bus.miss_i) begin
                        state_reg   <= FETCH;
                        adr_reg     <= bus.miss_adr_i[AWID-1:14];
                        asid_reg    <= bus.asid_i;
                        madr_reg    <= madr_next;
                        mreq_reg    <= 1'b1;
`ifdef ANY1_TLB_REFILL_TIMEOUT_EN
                        tmo_cnt_reg <= 8'd0;
`endif
                    end else if (bus.sw_req_i && bus.sw_we_i) begin
                        state_reg  <= SWWR;
                        tlben_reg  <= 1'b1;
                        wrtlb_reg  <= 1'b1;
                        tlbadr_reg <= bus.sw_adr_i;
                        tlbdat_reg <= bus.sw_dat_i;
                        sw_ack_reg <= 1'b1;
                    end else if (bus.sw_req_i) begin
                        state_reg  <= SWRD1;
                        tlben_reg  <= 1'b1;
                        tlbadr_reg <= bus.sw_adr_i;
                    end
                end
                FETCH: begin
                    if (bus.mack_i) begin
                        mreq_reg <= 1'b0;
                        if (bus.merr_i || !bus.mdat_i[0]) begin
                            state_reg <= FAULT;
                            fault_reg <= 1'b1;
                        end else begin
                            state_reg  <= WRITE;
                            tlben_reg  <= 1'b1;
                            wrtlb_reg  <= 1'b1;
                            tlbadr_reg <= {way_reg, adr_reg[23:14]};
                            tlbdat_reg <= pte_entry;
                        end
                    end
`ifdef ANY1_TLB_REFILL_TIMEOUT_EN
                    else if (tmo_cnt_reg == TMO_LIM) begin
                        mreq_reg  <= 1'b0;
                        state_reg <= FAULT;
                        fault_reg <= 1'b1;
                    end else begin
                        tmo_cnt_reg <= tmo_cnt_reg + 8'd1;
                    end
`endif
                end
                WRITE: begin
                    way_reg   <= way_reg + 2'd1;
                    state_reg <= DONE;
                    done_reg  <= 1'b1;
                end
                DONE:  state_reg <= IDLE;
                FAULT: state_reg <= IDLE;
                SWWR:  state_reg <= IDLE;
                SWRD1: begin
                    state_reg  <= SWRD2;
                    tlben_reg  <= 1'b1;
                    sw_ack_reg <= 1'b1;
                end
                SWRD2: begin
                    sw_dat_reg <= bus.tlbdat_i;
                    state_reg  <= IDLE;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign bus.mreq_o   = mreq_reg;
    assign bus.madr_o   = madr_reg;
    assign bus.tlben_o  = tlben_reg;
    assign bus.wrtlb_o  = wrtlb_reg;
    assign bus.tlbadr_o = tlbadr_reg;
    assign bus.tlbdat_o = tlbdat_reg;
    assign bus.sw_ack_o = sw_ack_reg;
    assign bus.sw_dat_o = sw_dat_reg;
    assign bus.done_o   = done_reg;
    assign bus.fault_o  = fault_reg;
endmodule

// File: tb/tb_any1_tlb_refill.sv
// tb_any1_tlb_refill: scoreboard bench for any1_tlb_refill. Expected TLB writes
// are queued when a miss is issued. Observed writes are queued by the driver,
// and each test pops and compares them.
module tb_any1_tlb_refill;
    localparam int AWID   = 32;
    localparam int TMO_TB = 4;

    logic clk_i = 1'b0;
    logic rst_i = 1'b0;
    int   errors = 0;
    int   checks = 0;
    int   exp_way = 0;

    logic [11:0] exp_adr_q[$];
    logic [11:0] obs_adr_q[$];
    logic [63:0] exp_dat_q[$];
    logic [63:0] obs_dat_q[$];

    any1_tlb_refill_if #(.AWID(AWID)) bus();

    any1_tlb_refill #(.AWID(AWID), .TMO(TMO_TB)) dut (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .bus   (bus)
    );

    always #5 clk_i = ~clk_i;

    // TLB RAM model: read data is a fixed tag plus the address presented.
    assign bus.tlbdat_i = {16'hC0DE, 36'h0, bus.tlbadr_o};

    function automatic logic [63:0] model_entry(logic [31:0] adr, logic [7:0] asid,
                                                logic [63:0] pte);
        logic [63:0] e;
        e        = 64'd0;
        e[63:56] = asid;
        e[55]    = pte[5];
        e[51:48] = pte[4:1];
        e[39:32] = adr[31:24];
        e[17:0]  = pte[31:14];
        return e;
    endfunction

    task automatic push_expected(input logic [31:0] adr, input logic [7:0] asid,
                                 input logic [63:0] pte);
        logic [1:0] w;
        w = exp_way[1:0];
        exp_adr_q.push_back({w, adr[23:14]});
        exp_dat_q.push_back(model_entry(adr, asid, pte));
        exp_way = (exp_way + 1) % 4;
    endtask

    task automatic reset_dut();
        @(negedge clk_i);
        rst_i = 1'b0;
        bus.miss_i = 1'b0; bus.sw_req_i = 1'b0; bus.mack_i = 1'b0; bus.merr_i = 1'b0;
        @(negedge clk_i);
        rst_i = 1'b1;
        exp_way = 0;
    endtask

    // Drives one miss, acknowledging in the first FETCH cycle. Records TLB
    // writes. cyc is the cycle in which done_o/fault_o is seen, where the cycle
    // that first presents miss_i is cycle 1.
    task automatic run_miss(input logic [31:0] adr, input logic [7:0] asid,
                            input logic [63:0] pte, input logic err,
                            output int cyc, output logic got_done, output logic got_fault,
                            output logic timed_out, output logic [31:0] madr_seen);
        logic acked;
        logic fin;
        acked = 1'b0; fin = 1'b0; cyc = 0; got_done = 1'b0; got_fault = 1'b0;
        madr_seen = '0;
        @(negedge clk_i);
        bus.miss_i = 1'b1; bus.miss_adr_i = adr; bus.asid_i = asid;
        for (int n = 1; n <= 40 && !fin; n++) begin
            @(negedge clk_i);
            if (acked && bus.mack_i) bus.mack_i = 1'b0;
            if (bus.wrtlb_o) begin
                obs_adr_q.push_back(bus.tlbadr_o);
                obs_dat_q.push_back(bus.tlbdat_o);
            end
            if (bus.mreq_o && !acked) begin
                bus.mack_i = 1'b1; bus.merr_i = err; bus.mdat_i = pte;
                acked = 1'b1; madr_seen = bus.madr_o;
            end
            if (bus.done_o || bus.fault_o) begin
                got_done = bus.done_o; got_fault = bus.fault_o;
                cyc = n + 1; fin = 1'b1; bus.miss_i = 1'b0;
            end
        end
        timed_out = !fin;
        bus.miss_i = 1'b0; bus.mack_i = 1'b0; bus.merr_i = 1'b0;
    endtask

    task automatic test_reset();
        reset_dut();
        checks++;
        if ({bus.mreq_o, bus.wrtlb_o, bus.tlben_o, bus.sw_ack_o, bus.done_o, bus.fault_o} !== 6'b0) begin
            errors++; $display("FAIL reset_strobes: got %b expected 000000",
                {bus.mreq_o, bus.wrtlb_o, bus.tlben_o, bus.sw_ack_o, bus.done_o, bus.fault_o});
        end
        checks++;
        if ({bus.madr_o, bus.tlbadr_o} !== 44'd0) begin
            errors++; $display("FAIL reset_addr: got madr=%h tlbadr=%h expected 0", bus.madr_o, bus.tlbadr_o);
        end
        checks++;
        if ({bus.tlbdat_o, bus.sw_dat_o} !== 128'd0) begin
            errors++; $display("FAIL reset_data: got tlbdat=%h sw_dat=%h expected 0", bus.tlbdat_o, bus.sw_dat_o);
        end
        $display("reset: outputs checked");
    endtask

    task automatic test_refill_basic();
        int cyc; logic d, f, t; logic [31:0] ma; logic [11:0] oa; logic [63:0] od;
        bus.ptbr_i = 32'h0000_1000;
        push_expected(32'h0012_C000, 8'd5, 64'h0003_C00B);
        run_miss(32'h0012_C000, 8'd5, 64'h0003_C00B, 1'b0, cyc, d, f, t, ma);
        $display("refill adr=0012c000 asid=5 madr=%h done=%b cyc=%0d", ma, d, cyc);
        checks++; if (ma !== 32'h0000_1258) begin errors++; $display("FAIL basic_madr: got %h expected 00001258", ma); end
        checks++; if ({t, d, f} !== 3'b010) begin errors++; $display("FAIL basic_done: got tmo/done/fault=%b expected 010", {t, d, f}); end
        checks++; if (cyc !== 4) begin errors++; $display("FAIL basic_latency: got %0d expected 4", cyc); end
        checks++;
        if (obs_adr_q.size() !== 1) begin
            errors++; $display("FAIL basic_write_count: got %0d expected 1", obs_adr_q.size());
        end else begin
            oa = obs_adr_q.pop_front(); od = obs_dat_q.pop_front();
            checks++; if (oa !== 12'h04B) begin errors++; $display("FAIL basic_tlbadr: got %h expected 04b", oa); end
            checks++; if (od !== 64'h0505_0000_0000_000F) begin errors++; $display("FAIL basic_tlbdat: got %h expected 050500000000000f", od); end
        end
        exp_adr_q.delete(); exp_dat_q.delete(); obs_adr_q.delete(); obs_dat_q.delete();
    endtask

    task automatic test_round_robin();
        int cyc; logic d, f, t; logic [31:0] ma, adr; logic [63:0] pte; logic [7:0] asid;
        logic [11:0] ea, oa; logic [63:0] ed, od;
        reset_dut();
        for (int i = 0; i < 5; i++) begin
            adr  = $urandom;
            asid = 8'($urandom);
            pte  = {32'($urandom), 32'($urandom)} | 64'd1;
            push_expected(adr, asid, pte);
            run_miss(adr, asid, pte, 1'b0, cyc, d, f, t, ma);
            checks++;
            if (obs_adr_q.size() !== 1 || exp_adr_q.size() !== 1) begin
                errors++; $display("FAIL rr_write_count: got %0d expected 1", obs_adr_q.size());
                obs_adr_q.delete(); obs_dat_q.delete(); exp_adr_q.delete(); exp_dat_q.delete();
            end else begin
                ea = exp_adr_q.pop_front(); ed = exp_dat_q.pop_front();
                oa = obs_adr_q.pop_front(); od = obs_dat_q.pop_front();
                $display("refill %0d adr=%h tlbadr=%h tlbdat=%h", i, adr, oa, od);
                checks++; if (oa[11:10] !== 2'(i % 4)) begin errors++; $display("FAIL rr_way: got %0d expected %0d", oa[11:10], i % 4); end
                checks++; if (oa !== ea) begin errors++; $display("FAIL rr_tlbadr: got %h expected %h", oa, ea); end
                checks++; if (od !== ed) begin errors++; $display("FAIL rr_tlbdat: got %h expected %h", od, ed); end
            end
        end
    endtask

    task automatic test_fault();
        int cyc; logic d, f, t; logic [31:0] ma; logic [11:0] ea, oa;
        run_miss(32'h0ABC_4000, 8'd9, 64'h0003_C00A, 1'b0, cyc, d, f, t, ma);
        $display("invalid pte: done=%b fault=%b writes=%0d", d, f, obs_adr_q.size());
        checks++; if ({t, d, f} !== 3'b001) begin errors++; $display("FAIL invalid_fault: got tmo/done/fault=%b expected 001", {t, d, f}); end
        checks++; if (obs_adr_q.size() !== 0) begin errors++; $display("FAIL invalid_nowrite: got %0d writes expected 0", obs_adr_q.size()); end
        run_miss(32'h0ABC_8000, 8'd9, 64'h0003_C00B, 1'b1, cyc, d, f, t, ma);
        $display("merr: done=%b fault=%b writes=%0d", d, f, obs_adr_q.size());
        checks++; if ({t, d, f} !== 3'b001) begin errors++; $display("FAIL merr_fault: got tmo/done/fault=%b expected 001", {t, d, f}); end
        checks++; if (obs_adr_q.size() !== 0) begin errors++; $display("FAIL merr_nowrite: got %0d writes expected 0", obs_adr_q.size()); end
        obs_adr_q.delete(); obs_dat_q.delete();
        push_expected(32'h0040_0000, 8'd1, 64'h0000_4021);
        run_miss(32'h0040_0000, 8'd1, 64'h0000_4021, 1'b0, cyc, d, f, t, ma);
        checks++;
        if (obs_adr_q.size() !== 1) begin
            errors++; $display("FAIL fault_way_count: got %0d expected 1", obs_adr_q.size());
        end else begin
            ea = exp_adr_q.pop_front(); oa = obs_adr_q.pop_front();
            $display("refill after faults tlbadr=%h", oa);
            checks++; if (oa !== ea) begin errors++; $display("FAIL fault_way_kept: got %h expected %h", oa, ea); end
            checks++; if (obs_dat_q.pop_front() !== exp_dat_q.pop_front()) begin errors++; $display("FAIL fault_after_tlbdat: entry differs"); end
        end
        exp_adr_q.delete(); exp_dat_q.delete(); obs_adr_q.delete(); obs_dat_q.delete();
    endtask

    task automatic test_arbitration();
        logic acked, seen_done, fin; logic [63:0] swd; logic [11:0] ea, oa; logic [63:0] ed, od;
        acked = 1'b0; seen_done = 1'b0; fin = 1'b0;
        swd = {32'($urandom), 32'($urandom)};
        push_expected(32'h1234_C000, 8'h7E, 64'h0001_0027);
        exp_adr_q.push_back(12'h3A7); exp_dat_q.push_back(swd);
        @(negedge clk_i);
        bus.miss_i = 1'b1; bus.miss_adr_i = 32'h1234_C000; bus.asid_i = 8'h7E;
        bus.sw_req_i = 1'b1; bus.sw_we_i = 1'b1; bus.sw_adr_i = 12'h3A7; bus.sw_dat_i = swd;
        for (int n = 1; n <= 40 && !fin; n++) begin
            @(negedge clk_i);
            if (acked && bus.mack_i) bus.mack_i = 1'b0;
            if (bus.wrtlb_o) begin obs_adr_q.push_back(bus.tlbadr_o); obs_dat_q.push_back(bus.tlbdat_o); end
            if (bus.mreq_o && !acked) begin
                bus.mack_i = 1'b1; bus.merr_i = 1'b0; bus.mdat_i = 64'h0001_0027; acked = 1'b1;
            end
            if (bus.done_o) begin seen_done = 1'b1; bus.miss_i = 1'b0; end
            if (bus.sw_ack_o) begin
                checks++; if (seen_done !== 1'b1) begin errors++; $display("FAIL arb_order: got sw_ack before done expected refill first"); end
                bus.sw_req_i = 1'b0; fin = 1'b1;
            end
        end
        bus.miss_i = 1'b0; bus.sw_req_i = 1'b0; bus.mack_i = 1'b0;
        checks++; if (fin !== 1'b1) begin errors++; $display("FAIL arb_sw_ack: got no sw_ack_o expected one within 40 cycles"); end
        checks++;
        if (obs_adr_q.size() !== 2) begin
            errors++; $display("FAIL arb_write_count: got %0d expected 2", obs_adr_q.size());
        end else begin
            for (int k = 0; k < 2; k++) begin
                ea = exp_adr_q.pop_front(); ed = exp_dat_q.pop_front();
                oa = obs_adr_q.pop_front(); od = obs_dat_q.pop_front();
                $display("arb write %0d tlbadr=%h tlbdat=%h", k, oa, od);
                checks++; if (oa !== ea || od !== ed) begin errors++; $display("FAIL arb_write%0d: got %h/%h expected %h/%h", k, oa, od, ea, ed); end
            end
        end
        exp_adr_q.delete(); exp_dat_q.delete(); obs_adr_q.delete(); obs_dat_q.delete();
    endtask

    task automatic test_sw_read();
        logic fin, wrote; int cyc; logic d, f, t; logic [31:0] ma;
        fin = 1'b0; wrote = 1'b0;
        @(negedge clk_i);
        bus.sw_req_i = 1'b1; bus.sw_we_i = 1'b0; bus.sw_adr_i = 12'h805;
        for (int n = 1; n <= 20 && !fin; n++) begin
            @(negedge clk_i);
            if (bus.wrtlb_o) wrote = 1'b1;
            if (bus.sw_ack_o) begin bus.sw_req_i = 1'b0; fin = 1'b1; end
        end
        bus.sw_req_i = 1'b0;
        @(negedge clk_i);
        $display("sw read adr=805 ack=%b sw_dat=%h", fin, bus.sw_dat_o);
        checks++; if (fin !== 1'b1) begin errors++; $display("FAIL swrd_ack: got no ack expected ack"); end
        checks++; if (wrote !== 1'b0) begin errors++; $display("FAIL swrd_nowrite: got wrtlb during read expected none"); end
        checks++; if (bus.sw_dat_o !== 64'hC0DE_0000_0000_0805) begin errors++; $display("FAIL swrd_data: got %h expected c0de000000000805", bus.sw_dat_o); end
        push_expected(32'h0000_8000, 8'd2, 64'h0000_8001);
        run_miss(32'h0000_8000, 8'd2, 64'h0000_8001, 1'b0, cyc, d, f, t, ma);
        checks++; if (bus.sw_dat_o !== 64'hC0DE_0000_0000_0805) begin errors++; $display("FAIL swrd_hold: got %h expected c0de000000000805", bus.sw_dat_o); end
        exp_adr_q.delete(); exp_dat_q.delete(); obs_adr_q.delete(); obs_dat_q.delete();
    endtask

    task automatic test_reset_mid_fetch();
        logic seen; logic wrote; int cyc; logic d, f, t; logic [31:0] ma; logic [11:0] oa;
        seen = 1'b0; wrote = 1'b0;
        @(negedge clk_i);
        bus.miss_i = 1'b1; bus.miss_adr_i = 32'h00FF_C000; bus.asid_i = 8'd3;
        for (int n = 0; n < 10 && !seen; n++) begin
            @(negedge clk_i);
            if (bus.mreq_o) seen = 1'b1;
        end
        checks++; if (seen !== 1'b1) begin errors++; $display("FAIL rstf_mreq: got no mreq_o expected mreq_o"); end
        rst_i = 1'b0; bus.miss_i = 1'b0;
        @(negedge clk_i);
        $display("reset mid-fetch: mreq=%b madr=%h tlbadr=%h", bus.mreq_o, bus.madr_o, bus.tlbadr_o);
        checks++;
        if ({bus.mreq_o, bus.wrtlb_o, bus.tlben_o, bus.sw_ack_o, bus.done_o, bus.fault_o} !== 6'b0
            || bus.madr_o !== 32'd0 || bus.tlbadr_o !== 12'd0 || bus.tlbdat_o !== 64'd0 || bus.sw_dat_o !== 64'd0) begin
            errors++; $display("FAIL rstf_outputs: got mreq=%b madr=%h tlbadr=%h tlbdat=%h sw_dat=%h expected all 0",
                bus.mreq_o, bus.madr_o, bus.tlbadr_o, bus.tlbdat_o, bus.sw_dat_o);
        end
        rst_i = 1'b1; exp_way = 0;
        bus.mack_i = 1'b1; bus.merr_i = 1'b0; bus.mdat_i = 64'h0003_C00B;
        for (int n = 0; n < 6; n++) begin
            @(negedge clk_i);
            bus.mack_i = 1'b0;
            if (bus.wrtlb_o || bus.done_o || bus.fault_o || bus.mreq_o) wrote = 1'b1;
        end
        checks++; if (wrote !== 1'b0) begin errors++; $display("FAIL rstf_late_ack: got activity expected none"); end
        push_expected(32'h0001_4000, 8'd4, 64'h0000_4003);
        run_miss(32'h0001_4000, 8'd4, 64'h0000_4003, 1'b0, cyc, d, f, t, ma);
        checks++;
        if (obs_adr_q.size() !== 1) begin
            errors++; $display("FAIL rstf_write_count: got %0d expected 1", obs_adr_q.size());
        end else begin
            oa = obs_adr_q.pop_front();
            checks++; if (oa !== exp_adr_q.pop_front()) begin errors++; $display("FAIL rstf_way0: got %h expected way 0 index 005", oa); end
        end
        exp_adr_q.delete(); exp_dat_q.delete(); obs_adr_q.delete(); obs_dat_q.delete();
    endtask

    task automatic test_timeout();
        logic seen; int k; int lows;
        seen = 1'b0; k = 0; lows = 0;
        @(negedge clk_i);
        bus.miss_i = 1'b1; bus.miss_adr_i = 32'h0002_0000; bus.asid_i = 8'd6;
        for (int n = 0; n < 10 && !seen; n++) begin
            @(negedge clk_i);
            if (bus.mreq_o) seen = 1'b1;
        end
        checks++; if (seen !== 1'b1) begin errors++; $display("FAIL tmo_mreq: got no mreq_o expected mreq_o"); end
`ifdef ANY1_TLB_REFILL_TIMEOUT_EN
        for (int n = 1; n <= 20 && k == 0; n++) begin
            @(negedge clk_i);
            if (bus.fault_o) begin
                k = n; bus.miss_i = 1'b0;
                checks++; if (bus.mreq_o !== 1'b0) begin errors++; $display("FAIL tmo_mreq_drop: got %b expected 0", bus.mreq_o); end
            end
        end
        $display("timeout: fault after %0d cycles", k);
        checks++; if (k !== 5) begin errors++; $display("FAIL tmo_latency: got %0d expected 5", k); end
`else
        for (int n = 0; n < 1000; n++) begin
            @(negedge clk_i);
            if (!bus.mreq_o || bus.fault_o) lows++;
        end
        $display("no timeout: mreq low/fault cycles=%0d over 1000", lows);
        checks++; if (lows !== 0) begin errors++; $display("FAIL notmo_wait: got %0d idle cycles expected 0", lows); end
`endif
        bus.miss_i = 1'b0;
        reset_dut();
    endtask

    initial begin
        bus.miss_i = 1'b0; bus.miss_adr_i = '0; bus.asid_i = '0; bus.ptbr_i = '0;
        bus.mack_i = 1'b0; bus.merr_i = 1'b0; bus.mdat_i = '0;
        bus.sw_req_i = 1'b0; bus.sw_we_i = 1'b0; bus.sw_adr_i = '0; bus.sw_dat_i = '0;
        test_reset();
        test_refill_basic();
        test_round_robin();
        test_fault();
        test_arbitration();
        test_sw_read();
        test_reset_mid_fetch();
        test_timeout();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
